// File: rtl/cache_line_burst_controller.sv
// Cache-line burst sequencer in front of BurstRAM: turns one line request into one
// burst command plus BURST_COUNT streamed write beats or BURST_COUNT collected read beats.
module cache_line_burst_controller #(
  parameter int DATA_BITWIDTH  = 64,
  parameter int DEPTH_BITWIDTH = 8,
  parameter int BURST_COUNT    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req_en,
  input  logic                                   req_write,
  input  logic [DEPTH_BITWIDTH-1:0]              req_addr,
  input  logic [DATA_BITWIDTH*BURST_COUNT-1:0]   req_wr_line,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err,
  output logic [DATA_BITWIDTH*BURST_COUNT-1:0]   rd_line,
  output logic                                   br_cmd,
  output logic                                   br_cmd_en,
  output logic [DEPTH_BITWIDTH-1:0]              br_addr,
  output logic [DATA_BITWIDTH-1:0]               br_wr_data,
  output logic [DATA_BITWIDTH/8-1:0]             br_data_mask,
  input  logic [DATA_BITWIDTH-1:0]               br_rd_data,
  input  logic                                   br_rd_data_valid,
  input  logic                                   br_busy,
  output logic [2:0]                             dbgState
);
  localparam int BEAT_BITS = $clog2(BURST_COUNT);
  localparam int WD_BITS   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BEAT_BITS-1:0]      BEAT_LAST  = BEAT_BITS'(BURST_COUNT - 1);
  localparam logic [WD_BITS-1:0]        WD_LAST    = WD_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [DEPTH_BITWIDTH-1:0] ALIGN_MASK = ~DEPTH_BITWIDTH'(BURST_COUNT - 1);

  localparam logic [2:0] S_INIT     = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_WR_BEATS = 3'd3;
  localparam logic [2:0] S_WR_DRAIN = 3'd4;
  localparam logic [2:0] S_RD_BEATS = 3'd5;
  localparam logic [2:0] S_FINISH   = 3'd6;

  logic [2:0]                           state;
  logic [2:0]                           nextState;
  logic [BEAT_BITS-1:0]                 beatCnt;
  logic [WD_BITS-1:0]                   wdCnt;
  logic                                 lineWrite;
  logic [DEPTH_BITWIDTH-1:0]            lineAddr;
  logic [DATA_BITWIDTH*BURST_COUNT-1:0] lineData;
  logic                                 accept;
  logic                                 timeout;
  logic                                 counting;
  logic                                 wdExpired;

  // Request handshake: req_en is a valid strobe, busy is the inverted ready. A request
  // is taken on an edge where req_en=1 and busy=0; requests seen while busy are dropped.
  assign counting     = (state == S_ISSUE) || (state == S_WR_DRAIN) || (state == S_RD_BEATS);
  assign wdExpired    = counting && (wdCnt == WD_LAST);
  assign br_data_mask = '0;
  assign dbgState     = state;

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_INIT: if (!br_busy) nextState = S_IDLE;
      S_IDLE,
      S_FINISH: begin
        nextState = S_IDLE;
        if (req_en) begin
          accept    = 1'b1;
          nextState = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!br_busy) nextState = lineWrite ? S_WR_BEATS : S_RD_BEATS;
        else if (wdExpired) begin
          timeout   = 1'b1;
          nextState = S_FINISH;
        end
      end
      S_WR_BEATS: if (beatCnt == BEAT_LAST) nextState = S_WR_DRAIN;
      S_WR_DRAIN: begin
        if (!br_busy) nextState = S_FINISH;
        else if (wdExpired) begin
          timeout   = 1'b1;
          nextState = S_FINISH;
        end
      end
      S_RD_BEATS: begin
        if (br_rd_data_valid && (beatCnt == BEAT_LAST)) nextState = S_FINISH;
        else if (wdExpired) begin
          timeout   = 1'b1;
          nextState = S_FINISH;
        end
      end
      default: nextState = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      busy       <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      br_cmd_en  <= 1'b0;
      br_cmd     <= 1'b0;
      br_addr    <= '0;
      br_wr_data <= '0;
      rd_line    <= '0;
      beatCnt    <= '0;
      wdCnt      <= '0;
      lineWrite  <= 1'b0;
      lineAddr   <= '0;
      lineData   <= '0;
    end else begin
      state     <= nextState;
      busy      <= !((nextState == S_IDLE) || (nextState == S_FINISH));
      done      <= (nextState == S_FINISH);
      err       <= timeout;
      br_cmd_en <= 1'b0;

      if (accept) begin
        lineWrite <= req_write;
        lineAddr  <= req_addr & ALIGN_MASK;
        lineData  <= req_wr_line;
        wdCnt     <= '0;
      end else if (counting) begin
        wdCnt <= wdCnt + 1'b1;
      end

      case (state)
        S_ISSUE: begin
          if (!br_busy) begin
            br_cmd_en  <= 1'b1;
            br_cmd     <= lineWrite;
            br_addr    <= lineAddr;
            br_wr_data <= lineData[DATA_BITWIDTH-1:0];
            beatCnt    <= lineWrite ? BEAT_BITS'(1) : '0;
          end
        end
        S_WR_BEATS: begin
          br_wr_data <= lineData[int'(beatCnt)*DATA_BITWIDTH +: DATA_BITWIDTH];
          beatCnt    <= beatCnt + 1'b1;
        end
        S_RD_BEATS: begin
          if (br_rd_data_valid) begin
            rd_line[int'(beatCnt)*DATA_BITWIDTH +: DATA_BITWIDTH] <= br_rd_data;
            beatCnt <= beatCnt + 1'b1;
          end
          // An abandoned read keeps its partial slots but restarts slot counting.
          if (timeout) beatCnt <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_line_burst_controller.sv
// Bench for cache_line_burst_controller: a small BurstRAM stand-in plus scoreboard
// queues for commands, write beats and read lines.
`timescale 1ns/1ps
module tb_cache_line_burst_controller;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int BC = 4;
  localparam int TO = 64;
  localparam int LW = DW * BC;
  localparam int INIT_CYC = 10;
  localparam int RD_DELAY = 3;
  localparam int WR_TAIL  = 4;
  localparam int WR_DONE_LAT = WR_TAIL + 2;
  localparam int RD_DONE_LAT = RD_DELAY + BC + 1;

  logic          clk;
  logic          rst;
  logic          req_en;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_wr_line;
  logic          busy;
  logic          done;
  logic          err;
  logic [LW-1:0] rd_line;
  logic          br_cmd;
  logic          br_cmd_en;
  logic [AW-1:0] br_addr;
  logic [DW-1:0] br_wr_data;
  logic [DW/8-1:0] br_data_mask;
  logic [DW-1:0] br_rd_data;
  logic          br_rd_data_valid;
  logic          br_busy;
  logic [2:0]    dbgState;

  cache_line_burst_controller #(
    .DATA_BITWIDTH(DW), .DEPTH_BITWIDTH(AW), .BURST_COUNT(BC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_write(req_write), .req_addr(req_addr),
    .req_wr_line(req_wr_line), .busy(busy), .done(done), .err(err), .rd_line(rd_line),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
    .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
    .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy), .dbgState(dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  logic [DW-1:0]  expBeatQ[$];
  logic [LW-1:0]  expLineQ[$];
  logic [AW:0]    expCmdQ[$];

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // BurstRAM stand-in state
  logic [DW-1:0] mem [256];
  int cyc = 0;
  int cmdCyc = 0;
  int doneCyc = 0;
  int doneCount = 0;
  int cmdCount = 0;
  int rdConsumed = 0;
  int rdBeatsToSend = BC;
  int initCnt = INIT_CYC;
  int wrBusyCnt = 0;
  int rdWait = 0;
  int rdLeft = 0;
  int rdIdx = 0;
  int wrIdx = BC;
  logic [AW-1:0] rdAddr, wrAddr;
  logic lastCmdWrite = 1'b0;
  logic lastDoneErr = 1'b0;
  logic sRst, sCmdEn, sCmd, sDone, sErr, sValid;
  logic [AW-1:0] sAddr;
  logic [DW-1:0] sWd;
  logic [DW/8-1:0] sMask;
  logic [LW-1:0] sLine;

  initial begin
    br_busy = 1'b1;
    br_rd_data_valid = 1'b0;
    br_rd_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
    forever begin
      @(posedge clk);
      cyc++;
      sRst = rst; sCmdEn = br_cmd_en; sCmd = br_cmd; sAddr = br_addr; sWd = br_wr_data;
      sMask = br_data_mask; sDone = done; sErr = err; sLine = rd_line; sValid = br_rd_data_valid;
      #1;
      if (sRst) begin
        initCnt = INIT_CYC; rdLeft = 0; rdWait = 0; wrIdx = BC; wrBusyCnt = 0;
        br_rd_data_valid = 1'b0;
      end else begin
        if (initCnt > 0) initCnt--;
        if (wrBusyCnt > 0) wrBusyCnt--;
        if (sValid) rdConsumed++;
        if (sDone) begin
          doneCount++; doneCyc = cyc; lastDoneErr = sErr;
          if (!lastCmdWrite) begin
            if (expLineQ.size() == 0) check("rd_line_unexpected", LW'(1), LW'(0));
            else check("rd_line", sLine, expLineQ.pop_front());
          end
        end
        if (wrIdx < BC) begin
          if (expBeatQ.size() == 0) check("wr_beat_unexpected", LW'(1), LW'(0));
          else check("wr_beat", LW'(sWd), LW'(expBeatQ.pop_front()));
          check("wr_mask", LW'(sMask), LW'(0));
          mem[wrAddr + 8'(wrIdx)] = sWd;
          wrIdx++;
        end
        if (sCmdEn) begin
          cmdCount++; cmdCyc = cyc; lastCmdWrite = sCmd;
          if (expCmdQ.size() == 0) check("cmd_unexpected", LW'(1), LW'(0));
          else check("cmd", LW'({sCmd, sAddr}), LW'(expCmdQ.pop_front()));
          if (sCmd) begin
            if (expBeatQ.size() == 0) check("wr_beat_unexpected", LW'(1), LW'(0));
            else check("wr_beat0", LW'(sWd), LW'(expBeatQ.pop_front()));
            check("wr_mask0", LW'(sMask), LW'(0));
            mem[sAddr] = sWd; wrAddr = sAddr; wrIdx = 1; wrBusyCnt = WR_TAIL;
          end else begin
            rdAddr = sAddr; rdIdx = 0; rdWait = RD_DELAY; rdLeft = rdBeatsToSend;
          end
          br_rd_data_valid = 1'b0;
        end else begin
          if (rdWait > 0) rdWait--;
          if (rdWait == 0 && rdLeft > 0) begin
            br_rd_data_valid = 1'b1;
            br_rd_data = mem[rdAddr + 8'(rdIdx)];
            rdIdx++; rdLeft--;
          end else begin
            br_rd_data_valid = 1'b0;
          end
        end
      end
      br_busy = (initCnt > 0) || (wrBusyCnt > 0);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic waitDone(input string tag, input int limit);
    int start;
    start = doneCount;
    for (int i = 0; i < limit && doneCount == start; i++) tick();
    check({tag, "_done"}, LW'(doneCount - start), LW'(1));
  endtask

  task automatic waitInit(input string tag);
    int waited;
    int cmdSeen;
    waited = 0; cmdSeen = 0;
    while (busy && waited < 50) begin
      tick(); waited++;
      if (br_cmd_en) cmdSeen++;
    end
    check({tag, "_wait"}, LW'(waited), LW'(INIT_CYC + 1));
    check({tag, "_cmd_en"}, LW'(cmdSeen), LW'(0));
  endtask

  task automatic request(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] line,
                         output int reqCyc);
    req_en = 1'b1; req_write = wr; req_addr = addr; req_wr_line = line;
    reqCyc = cyc + 1;
    tick();
    req_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount + 1);
    $fatal(1, "bench timeout");
  end

  logic [LW-1:0] wrLine;
  logic [LW-1:0] partial;
  int reqCyc, startCmd, startDone, prevDone, startCons, guard;

  initial begin
    rst = 1'b1; req_en = 1'b0; req_write = 1'b0; req_addr = '0; req_wr_line = '0;
    wrLine = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    repeat (3) tick();
    check("rst_busy", LW'(busy), LW'(1));
    check("rst_done", LW'(done), LW'(0));
    check("rst_err", LW'(err), LW'(0));
    check("rst_cmd_en", LW'(br_cmd_en), LW'(0));
    check("rst_cmd", LW'(br_cmd), LW'(0));
    check("rst_addr", LW'(br_addr), LW'(0));
    check("rst_wr_data", LW'(br_wr_data), LW'(0));
    check("rst_mask", LW'(br_data_mask), LW'(0));
    check("rst_rd_line", rd_line, LW'(0));
    check("rst_state", LW'(dbgState), LW'(0));
    rst = 1'b0;
    waitInit("init");

    // write line to 0x04
    expCmdQ.push_back({1'b1, 8'h04});
    for (int k = 0; k < BC; k++) expBeatQ.push_back(wrLine[k*DW +: DW]);
    startCmd = cmdCount;
    request(1'b1, 8'h04, wrLine, reqCyc);
    check("wr_busy", LW'(busy), LW'(1));
    waitDone("wr", 100);
    check("wr_cmd_lat", LW'(cmdCyc - reqCyc), LW'(2));
    check("wr_done_lat", LW'(doneCyc - cmdCyc), LW'(WR_DONE_LAT));
    check("wr_err", LW'(lastDoneErr), LW'(0));
    check("wr_done_pulse", LW'(done), LW'(0));
    check("wr_cmd_count", LW'(cmdCount - startCmd), LW'(1));
    check("wr_beats_left", LW'(expBeatQ.size()), LW'(0));

    // misaligned read-back, ignored mid-read request, back-to-back request in done cycle
    expCmdQ.push_back({1'b0, 8'h04});
    expLineQ.push_back(wrLine);
    startCmd = cmdCount;
    request(1'b0, 8'h07, '0, reqCyc);
    repeat (3) tick();
    req_en = 1'b1; req_write = 1'b1; req_addr = 8'h40;
    tick();
    req_en = 1'b0; req_write = 1'b0;
    guard = 0;
    while ((cyc + 1) < reqCyc + 2 + RD_DONE_LAT && guard < 50) begin tick(); guard++; end
    check("rd_done_now", LW'(done), LW'(1));
    expCmdQ.push_back({1'b0, 8'h04});
    expLineQ.push_back(wrLine);
    req_en = 1'b1; req_write = 1'b0; req_addr = 8'h04;
    tick();
    req_en = 1'b0;
    check("rd_done_lat", LW'(doneCyc - cmdCyc), LW'(RD_DONE_LAT));
    check("rd_err", LW'(lastDoneErr), LW'(0));
    check("rd_ignored_req", LW'(cmdCount - startCmd), LW'(1));
    prevDone = doneCyc;
    waitDone("b2b", 100);
    check("b2b_gap", LW'(cmdCyc - prevDone), LW'(2));
    check("b2b_err", LW'(lastDoneErr), LW'(0));

    // watchdog: only two beats come back
    rdBeatsToSend = 2;
    partial = wrLine;
    partial[0 +: DW] = mem[8];
    partial[DW +: DW] = mem[9];
    expCmdQ.push_back({1'b0, 8'h08});
    expLineQ.push_back(partial);
    request(1'b0, 8'h0A, '0, reqCyc);
    waitDone("wd", 200);
    check("wd_lat", LW'(doneCyc - (reqCyc + 1)), LW'(TO));
    check("wd_err", LW'(lastDoneErr), LW'(1));
    check("wd_err_pulse", LW'(err), LW'(0));
    check("wd_idle", LW'(busy), LW'(0));
    rdBeatsToSend = BC;
    expCmdQ.push_back({1'b0, 8'h04});
    expLineQ.push_back(wrLine);
    request(1'b0, 8'h04, '0, reqCyc);
    waitDone("post_wd", 100);
    check("post_wd_err", LW'(lastDoneErr), LW'(0));

    // reset in the middle of a read
    expCmdQ.push_back({1'b0, 8'h08});
    startCons = rdConsumed;
    startDone = doneCount;
    request(1'b0, 8'h08, '0, reqCyc);
    guard = 0;
    while (rdConsumed - startCons < 2 && guard < 50) begin tick(); guard++; end
    check("mid_rst_beats", LW'(rdConsumed - startCons), LW'(2));
    rst = 1'b1;
    tick();
    check("mid_rst_busy", LW'(busy), LW'(1));
    check("mid_rst_rd_line", rd_line, LW'(0));
    check("mid_rst_done", LW'(done), LW'(0));
    check("mid_rst_state", LW'(dbgState), LW'(0));
    rst = 1'b0;
    waitInit("recover");
    check("mid_rst_no_done", LW'(doneCount - startDone), LW'(0));
    expCmdQ.push_back({1'b0, 8'h04});
    expLineQ.push_back(wrLine);
    request(1'b0, 8'h05, '0, reqCyc);
    waitDone("recover_rd", 100);
    check("recover_err", LW'(lastDoneErr), LW'(0));

    repeat (4) tick();
    check("cmd_q_left", LW'(expCmdQ.size()), LW'(0));
    check("line_q_left", LW'(expLineQ.size()), LW'(0));

    // final report
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
